// File: rtl/ldl_fifo_pkg.sv
// ---------------------------------------------------------------------------
// ldl_fifo_pkg
// Shared definitions for the synchronous FIFO controller family.
//   FWFT_STANDARD   : read data appears the cycle after the pop.
//   FWFT_SHOW_AHEAD : the head entry is presented before it is popped.
//   fifo_depth()    : number of entries addressed by an AWIDTH-bit address.
// ---------------------------------------------------------------------------
package ldl_fifo_pkg;

  localparam int FWFT_STANDARD   = 32'sd0;
  localparam int FWFT_SHOW_AHEAD = 32'sd1;

  // Depth of a memory with an awidth-bit address.
  function automatic int fifo_depth(input int awidth);
    return 32'sd1 <<< awidth;
  endfunction

endpackage : ldl_fifo_pkg

// File: rtl/ldl_fifo_ptr.sv
// ---------------------------------------------------------------------------
// ldl_fifo_ptr
// One FIFO pointer: AWIDTH address bits plus a wrap bit, so the pointer runs
// modulo 2*D and full/empty can be told apart when the address bits match.
// Ports:
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset, zeroes the pointer
//   clr   : synchronous clear (FIFO flush)
//   inc   : advance the pointer by one at the next edge
//   pt    : current pointer value, AWIDTH+1 bits
//   wrap  : top bit of the pointer
// ---------------------------------------------------------------------------
module ldl_fifo_ptr #(
  parameter int AWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              inc,
  output logic [AWIDTH:0]   pt,
  output logic              wrap
);

  logic [AWIDTH:0] pt_r;

  // Pointer register: reset and clear win over increment.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pt_r <= {(AWIDTH+1){1'b0}};
    end else if (clr) begin
      pt_r <= {(AWIDTH+1){1'b0}};
    end else if (inc) begin
      pt_r <= pt_r + {{AWIDTH{1'b0}}, 1'b1};
    end else begin
      pt_r <= pt_r;
    end
  end

  assign pt   = pt_r;
  assign wrap = pt_r[AWIDTH];

endmodule : ldl_fifo_ptr

// File: rtl/ldl_sfifo_ctr_pf.sv
// ---------------------------------------------------------------------------
// ldl_sfifo_ctr_pf
// Synchronous FIFO controller with programmable almost-full/almost-empty
// thresholds and sticky overflow/underflow flags. It drives an external
// single-port-write / single-port-read synchronous memory.
// Parameters:
//   AWIDTH : memory address width, depth D = 2**AWIDTH (2..16)
//   FWFT   : 1 = show-ahead head entry, 0 = data one cycle after pop
// Ports:
//   clk, rst_n       : clock and synchronous active-low reset
//   flush            : synchronous clear of all entries
//   we, re           : push / pop requests
//   err_clr          : clear sticky ovf/udf
//   af_th, ae_th     : almost-full / almost-empty thresholds
//   empty, full      : status (empty = no readable head entry)
//   afull, aempty    : count >= af_th, count <= ae_th
//   wa, mw           : memory write address / enable
//   ra, mr           : memory read address / enable
//   rvalid           : memory read data valid this cycle
//   count, free      : stored entries and D - count
//   ovf, udf         : sticky overflow / underflow
// ---------------------------------------------------------------------------
module ldl_sfifo_ctr_pf
  import ldl_fifo_pkg::*;
#(
  parameter int AWIDTH = 8,
  parameter int FWFT   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              we,
  input  logic              re,
  input  logic              err_clr,
  input  logic [AWIDTH:0]   af_th,
  input  logic [AWIDTH:0]   ae_th,
  output logic              empty,
  output logic              full,
  output logic              afull,
  output logic              aempty,
  output logic [AWIDTH-1:0] wa,
  output logic              mw,
  output logic [AWIDTH-1:0] ra,
  output logic              mr,
  output logic              rvalid,
  output logic [AWIDTH:0]   count,
  output logic [AWIDTH:0]   free,
  output logic              ovf,
  output logic              udf
);

  localparam logic [AWIDTH:0] DEPTH_C = (AWIDTH+1)'(fifo_depth(AWIDTH));

  logic [AWIDTH:0]   w_pt_s;
  logic [AWIDTH:0]   r_pt_s;
  logic              w_wrap_s;
  logic              r_wrap_s;
  logic [AWIDTH:0]   count_s;
  logic              full_s;
  logic              empty_s;
  logic              push_s;
  logic              pop_s;
  logic              ovf_set_s;
  logic              udf_set_s;
  logic [AWIDTH-1:0] ra_s;
  logic              mr_s;
  logic              rvalid_s;
  logic              ovf_r;
  logic              udf_r;

  ldl_fifo_ptr #(.AWIDTH(AWIDTH)) u_wptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .inc   (push_s),
    .pt    (w_pt_s),
    .wrap  (w_wrap_s)
  );

  ldl_fifo_ptr #(.AWIDTH(AWIDTH)) u_rptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .inc   (pop_s),
    .pt    (r_pt_s),
    .wrap  (r_wrap_s)
  );

  assign count_s = w_pt_s - r_pt_s;
  // Same address bits but different wrap bits: writer is a full lap ahead.
  assign full_s  = (w_wrap_s != r_wrap_s) &&
                   (w_pt_s[AWIDTH-1:0] == r_pt_s[AWIDTH-1:0]);

  // Nothing is accepted while reset is held, so no memory strobes leak out.
  assign push_s  = rst_n & we & ~full_s & ~flush;
  assign pop_s   = rst_n & re & ~empty_s & ~flush;

  // A push that collides with an accepted pop while full is back-pressure
  // (the writer retries next cycle), not an overflow.
  assign ovf_set_s = we & full_s & ~flush & ~pop_s;
  assign udf_set_s = re & empty_s & ~flush;

  generate
    if (FWFT == FWFT_SHOW_AHEAD) begin : g_fwft
      logic [AWIDTH:0] r_nx_s;
      logic            empty_q_r;

      // Read pointer as it will be after this cycle; the memory is always
      // reading the entry that will be the head next cycle.
      assign r_nx_s = r_pt_s + {{AWIDTH{1'b0}}, pop_s};

      // Head-valid register: compares against the pre-update write pointer,
      // so a just-written entry is never read in the cycle it is written.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          empty_q_r <= 1'b1;
        end else if (flush) begin
          empty_q_r <= 1'b1;
        end else begin
          empty_q_r <= (r_nx_s == w_pt_s);
        end
      end

      assign empty_s  = empty_q_r;
      assign rvalid_s = ~empty_q_r;
      assign ra_s     = r_nx_s[AWIDTH-1:0];
      assign mr_s     = rst_n & ~flush & (r_nx_s != w_pt_s);
    end else begin : g_std
      logic rvalid_r;

      // Read data lands one cycle after the accepted pop.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          rvalid_r <= 1'b0;
        end else if (flush) begin
          rvalid_r <= 1'b0;
        end else begin
          rvalid_r <= pop_s;
        end
      end

      assign empty_s  = (w_pt_s == r_pt_s);
      assign rvalid_s = rvalid_r;
      assign ra_s     = r_pt_s[AWIDTH-1:0];
      assign mr_s     = pop_s;
    end
  endgenerate

  // Sticky error flags: a new error in the same cycle beats err_clr.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_r <= 1'b0;
      udf_r <= 1'b0;
    end else begin
      if (ovf_set_s) begin
        ovf_r <= 1'b1;
      end else if (err_clr) begin
        ovf_r <= 1'b0;
      end else begin
        ovf_r <= ovf_r;
      end
      if (udf_set_s) begin
        udf_r <= 1'b1;
      end else if (err_clr) begin
        udf_r <= 1'b0;
      end else begin
        udf_r <= udf_r;
      end
    end
  end

  assign empty  = empty_s;
  assign full   = full_s;
  assign afull  = (count_s >= af_th);
  assign aempty = (count_s <= ae_th);
  assign wa     = w_pt_s[AWIDTH-1:0];
  assign mw     = push_s;
  assign ra     = ra_s;
  assign mr     = mr_s;
  assign rvalid = rvalid_s;
  assign count  = count_s;
  assign free   = DEPTH_C - count_s;
  assign ovf    = ovf_r;
  assign udf    = udf_r;

endmodule : ldl_sfifo_ctr_pf
